ov_frame_writer: RTL and testbench
==================================

Name: ov_frame_writer

Overview:
Camera-side writer for the dual-port frame buffer. Samples the OV7670 byte stream (VSYNC/HREF/8-bit data, RGB444 mode) in the pixel-clock domain and packs byte pairs into 12-bit pixels. Generates write-port address, data and write-enable for the frame buffer, so the VGA read side always sees a row-aligned 640x480 image. Reports frame completion and geometry errors.

Parameters:
H_PIX, 640, active pixels per line
V_LINES, 480, active lines per frame
ADDR_W, 19, frame buffer address width (H_PIX*V_LINES must be <= 2^ADDR_W)

Ports:
clk  in  1  camera pixel clock (PCLK); all logic on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  capture enable; sampled only at frame start
vsync  in  1  camera VSYNC, high during vertical blanking
href  in  1  camera HREF, high while line bytes are valid
din  in  8  camera data byte
wea  out  1  frame buffer write enable, one cycle per pixel
addra  out  ADDR_W  frame buffer write address
dina  out  12  pixel {R[3:0],G[3:0],B[3:0]}
busy  out  1  high while in CAPTURE state
frame_done  out  1  one-cycle pulse when a frame is closed
overflow  out  1  sticky; set on any line/pixel beyond H_PIX/V_LINES
frame_cnt  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Reset: wea=0, addra=0, dina=0, busy=0, frame_done=0, overflow=0, frame_cnt=0. State=IDLE, byte phase=0, line=0, col=0, line_base=0.
- vsync and href are registered once; edges are detected on the registered copies. din is registered alongside href.
- States: IDLE -> SYNC on rst release. SYNC: wait for vsync falling edge; if en=1 there -> CAPTURE, with line=0, col=0, line_base=0, phase=0, overflow unchanged. If en=0, remain in SYNC. CAPTURE: vsync rising edge -> frame_done pulse for 1 cycle, frame_cnt+1, then SYNC.
- Capture: while registered href=1, phase toggles each byte. Phase 0 latches din[3:0] as R. Phase 1 forms the pixel from the latched R, din[7:4] as G and din[3:0] as B.
- Write timing: on a phase-1 byte with col<H_PIX and line<V_LINES, the next cycle drives wea=1, addra=line_base+col, dina=pixel. col then increments. Latency is 2 cycles from the second byte on the pins to wea high, including the input register.
- Out-of-range pixels: if col>=H_PIX or line>=V_LINES, there is no write, overflow is set, and col saturates.
- Line end: on the href falling edge, line+1, line_base+=H_PIX, col=0 and phase=0. A short line leaves the remaining addresses unwritten, with no shift of later lines. A dangling phase-1 half pixel is discarded.
- vsync rising mid-line (href still high): the frame closes, and no further writes occur.
- addra/dina hold their last value when wea=0.
- rst asserted mid-frame: all state and outputs return to reset values on the next edge, and there are no further writes until the next full vsync fall.
- overflow clears only on rst.

Test Plan:
- Nominal frame: vsync pulse, then 480 lines of 1280 bytes with byte pair 0x0A,0xBC -> 307200 writes of dina=0xABC, addra 0..307199 in order, one frame_done pulse, frame_cnt=1, overflow=0.
- Latency/packing: line 0 bytes 0x05,0x3C -> wea high exactly 2 cycles after the 0x3C edge, addra=0, dina=0x53C.
- Short line: line 3 with only 100 pixels, line 4 full -> line 4 first write at addra=2560; addresses 2020..2559 are never written.
- Long line/extra lines: line 0 with 642 pixels, plus 481 lines total -> writes stop at addra=639 on the long line, no write on line 480, overflow=1 and stays 1 across the next frame.
- en gating: en=0 at a vsync fall -> no wea for the whole frame, frame_cnt unchanged. en=1 at the next fall -> capture resumes at addra=0.
- Reset mid-frame: rst during line 100 -> outputs at reset values next cycle. With no new vsync fall, no writes even with href toggling. After a vsync pulse, capture starts at addra=0.

Source files
------------

// File: rtl/ov_frame_writer.sv
// ov_frame_writer: packs OV7670 RGB444 byte pairs into 12-bit pixels and writes them row-aligned into a frame buffer
// Ports:
//   clk, rst          camera pixel clock, synchronous active-high reset
//   en                capture enable, sampled at the vsync falling edge that starts a frame
//   vsync, href, din  camera sync signals and data byte
//   wea, addra, dina  frame buffer write port (address = line*H_PIX + col)
//   busy              high while capturing a frame
//   frame_done        one-cycle pulse when a captured frame closes
//   overflow          sticky flag for any pixel or line beyond H_PIX x V_LINES
//   frame_cnt         completed-frame counter, wraps
module ov_frame_writer #(
    parameter int H_PIX   = 640,
    parameter int V_LINES = 480,
    parameter int ADDR_W  = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        din,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [11:0]       dina,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic [7:0]        frame_cnt
);
    localparam int CW = $clog2(H_PIX + 1);
    localparam int LW = $clog2(V_LINES + 1);
    typedef enum logic [1:0] {IDLE, SYNC, CAPTURE} state_t;
    state_t state, state_nxt;
    logic vs_r, vs_rr, hr_r, hr_rr;
    logic [7:0] din_r;
    logic phase;
    logic [3:0] r_lat;
    logic [CW-1:0] col;
    logic [LW-1:0] line;
    logic [ADDR_W-1:0] line_base;
    logic vs_fall, vs_rise, hr_fall, start, close, in_range;
    assign vs_fall  = vs_rr & ~vs_r;
    assign vs_rise  = ~vs_rr & vs_r;
    assign hr_fall  = hr_rr & ~hr_r;
    assign in_range = (col < CW'(H_PIX)) && (line < LW'(V_LINES));
    assign busy     = state == CAPTURE;
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        close     = 1'b0;
        case (state)
            IDLE:    state_nxt = SYNC;
            SYNC:    if (vs_fall && en) begin
                         state_nxt = CAPTURE;
                         start     = 1'b1;
                     end
            CAPTURE: if (vs_rise) begin
                         state_nxt = SYNC;
                         close     = 1'b1;
                     end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_r       <= 1'b0;
            vs_rr      <= 1'b0;
            hr_r       <= 1'b0;
            hr_rr      <= 1'b0;
            din_r      <= '0;
            phase      <= 1'b0;
            r_lat      <= '0;
            col        <= '0;
            line       <= '0;
            line_base  <= '0;
            wea        <= 1'b0;
            addra      <= '0;
            dina       <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            vs_r       <= vsync;
            vs_rr      <= vs_r;
            hr_r       <= href;
            hr_rr      <= hr_r;
            din_r      <= din;
            wea        <= 1'b0;
            frame_done <= close;
            if (close)
                frame_cnt <= frame_cnt + 1'b1;
            if (start) begin
                line      <= '0;
                col       <= '0;
                line_base <= '0;
                phase     <= 1'b0;
            end else if (busy && !vs_rise) begin
                if (hr_fall) begin
                    // Next row always starts at its own base, so short lines never shift later rows;
                    // a dangling half pixel is dropped by clearing phase.
                    col   <= '0;
                    phase <= 1'b0;
                    if (line < LW'(V_LINES)) begin
                        line      <= line + 1'b1;
                        line_base <= line_base + ADDR_W'(H_PIX);
                    end
                end else if (hr_r) begin
                    phase <= ~phase;
                    if (!phase)
                        r_lat <= din_r[3:0];
                    else if (in_range) begin
                        wea   <= 1'b1;
                        addra <= line_base + ADDR_W'(col);
                        dina  <= {r_lat, din_r};
                        col   <= col + 1'b1;
                    end else
                        overflow <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ov_frame_writer.sv
// tb_ov_frame_writer: directed self-checking bench for ov_frame_writer on a reduced 8x4 frame
module tb_ov_frame_writer;
    localparam int H = 8;
    localparam int V = 4;
    localparam int AW = 8;
    logic clk = 1'b0, rst = 1'b1, en = 1'b1, vsync = 1'b1, href = 1'b0;
    logic [7:0] din = '0;
    logic wea, busy, frame_done, overflow;
    logic [AW-1:0] addra;
    logic [11:0] dina;
    logic [7:0] frame_cnt;
    int checks = 0, errors = 0, fd_cnt = 0;
    logic [AW-1:0] wq_a[$];
    logic [11:0] wq_d[$];

    ov_frame_writer #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .en(en), .vsync(vsync), .href(href), .din(din),
        .wea(wea), .addra(addra), .dina(dina), .busy(busy),
        .frame_done(frame_done), .overflow(overflow), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wea) begin
            wq_a.push_back(addra);
            wq_d.push_back(dina);
        end
        if (frame_done) fd_cnt++;
    end

    task automatic clear_log();
        wq_a.delete();
        wq_d.delete();
    endtask

    task automatic frame_start();
        href = 1'b0;
        vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end();
        href = 1'b0;
        vsync = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_line(input int npix, input logic [7:0] hi, input logic [7:0] lo, input bit extra);
        href = 1'b1;
        for (int p = 0; p < npix; p++) begin
            din = hi;
            @(negedge clk);
            din = lo;
            @(negedge clk);
        end
        if (extra) begin
            din = hi;
            @(negedge clk);
        end
        href = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_order(input string name, input int n, input logic [11:0] d);
        int bad = 0;
        for (int i = 0; i < wq_a.size(); i++)
            if (wq_a[i] !== AW'(i) || wq_d[i] !== d) bad++;
        checks++;
        if (wq_a.size() != n || bad != 0) begin
            errors++;
            $display("FAIL %s: writes=%0d bad=%0d, required writes=%0d bad=0", name, wq_a.size(), bad, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 7;
        if (wea !== 1'b0)       begin errors++; $display("FAIL rst_wea: got %b want 0", wea); end
        if (addra !== '0)       begin errors++; $display("FAIL rst_addra: got %0d want 0", addra); end
        if (dina !== '0)        begin errors++; $display("FAIL rst_dina: got %h want 000", dina); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd: got %b want 0", frame_done); end
        if (overflow !== 1'b0)  begin errors++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        if (frame_cnt !== 8'd0) begin errors++; $display("FAIL rst_fcnt: got %0d want 0", frame_cnt); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_nominal();
        clear_log();
        fd_cnt = 0;
        frame_start();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy: got %b want 1", busy); end
        for (int l = 0; l < V; l++) send_line(H, 8'h0A, 8'hBC, 0);
        frame_end();
        check_order("nom_writes", H * V, 12'hABC);
        checks += 4;
        if (fd_cnt != 1)        begin errors++; $display("FAIL nom_fd: got %0d want 1", fd_cnt); end
        if (frame_cnt !== 8'd1) begin errors++; $display("FAIL nom_fcnt: got %0d want 1", frame_cnt); end
        if (overflow !== 1'b0)  begin errors++; $display("FAIL nom_ovf: got %b want 0", overflow); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL nom_idle: got %b want 0", busy); end
    endtask

    task automatic test_latency();
        frame_start();
        href = 1'b1;
        din = 8'h05;
        @(negedge clk);
        din = 8'h3C;
        @(negedge clk);
        checks++;
        if (wea !== 1'b0) begin errors++; $display("FAIL lat_early: wea=%b want 0", wea); end
        href = 1'b0;
        @(negedge clk);
        checks += 3;
        if (wea !== 1'b1)     begin errors++; $display("FAIL lat_wea: got %b want 1", wea); end
        if (addra !== 8'd0)   begin errors++; $display("FAIL lat_addra: got %0d want 0", addra); end
        if (dina !== 12'h53C) begin errors++; $display("FAIL lat_dina: got %h want 53C", dina); end
        @(negedge clk);
        checks += 2;
        if (wea !== 1'b0)     begin errors++; $display("FAIL lat_pulse: wea=%b want 0", wea); end
        if (dina !== 12'h53C) begin errors++; $display("FAIL lat_hold: dina=%h want 53C", dina); end
        frame_end();
        checks++;
        if (frame_cnt !== 8'd2) begin errors++; $display("FAIL lat_fcnt: got %0d want 2", frame_cnt); end
    endtask

    task automatic test_short_line();
        int hole = 0;
        clear_log();
        frame_start();
        send_line(H, 8'h0A, 8'hBC, 0);
        send_line(3, 8'h0A, 8'hBC, 1);
        send_line(H, 8'h01, 8'h23, 0);
        send_line(H, 8'h0A, 8'hBC, 0);
        frame_end();
        foreach (wq_a[i]) if (wq_a[i] >= 8'd11 && wq_a[i] <= 8'd15) hole++;
        checks += 4;
        if (wq_a.size() != 27) begin errors++; $display("FAIL short_cnt: got %0d want 27", wq_a.size()); end
        if (hole != 0)         begin errors++; $display("FAIL short_hole: got %0d writes in 11..15 want 0", hole); end
        if (wq_a.size() > 11 && wq_a[11] !== 8'd16) begin errors++; $display("FAIL short_addr: got %0d want 16", wq_a[11]); end
        if (wq_d.size() > 11 && wq_d[11] !== 12'h123) begin errors++; $display("FAIL short_data: got %h want 123", wq_d[11]); end
    endtask

    task automatic test_overflow();
        clear_log();
        frame_start();
        send_line(H + 2, 8'h0A, 8'hBC, 0);
        for (int l = 1; l < V; l++) send_line(H, 8'h0A, 8'hBC, 0);
        send_line(H, 8'h0A, 8'hBC, 0);
        frame_end();
        check_order("ovf_writes", H * V, 12'hABC);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
        clear_log();
        frame_start();
        for (int l = 0; l < V; l++) send_line(H, 8'h0A, 8'hBC, 0);
        frame_end();
        check_order("ovf_next_writes", H * V, 12'hABC);
        checks += 2;
        if (overflow !== 1'b1)  begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        if (frame_cnt !== 8'd5) begin errors++; $display("FAIL ovf_fcnt: got %0d want 5", frame_cnt); end
    endtask

    task automatic test_en_gating();
        clear_log();
        fd_cnt = 0;
        en = 1'b0;
        frame_start();
        en = 1'b1;
        for (int l = 0; l < V; l++) send_line(H, 8'h0A, 8'hBC, 0);
        frame_end();
        checks += 3;
        if (wq_a.size() != 0)   begin errors++; $display("FAIL en_writes: got %0d want 0", wq_a.size()); end
        if (fd_cnt != 0)        begin errors++; $display("FAIL en_fd: got %0d want 0", fd_cnt); end
        if (frame_cnt !== 8'd5) begin errors++; $display("FAIL en_fcnt: got %0d want 5", frame_cnt); end
        frame_start();
        for (int l = 0; l < V; l++) send_line(H, 8'h0A, 8'hBC, 0);
        frame_end();
        check_order("en_resume", H * V, 12'hABC);
        checks++;
        if (frame_cnt !== 8'd6) begin errors++; $display("FAIL en_fcnt2: got %0d want 6", frame_cnt); end
    endtask

    task automatic test_reset_midframe();
        frame_start();
        send_line(H, 8'h0A, 8'hBC, 0);
        send_line(H, 8'h0A, 8'hBC, 0);
        href = 1'b1;
        din = 8'h0A;
        @(negedge clk);
        din = 8'hBC;
        rst = 1'b1;
        @(negedge clk);
        checks += 5;
        if (wea !== 1'b0)       begin errors++; $display("FAIL mid_wea: got %b want 0", wea); end
        if (addra !== '0)       begin errors++; $display("FAIL mid_addra: got %0d want 0", addra); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (overflow !== 1'b0)  begin errors++; $display("FAIL mid_ovf: got %b want 0", overflow); end
        if (frame_cnt !== 8'd0) begin errors++; $display("FAIL mid_fcnt: got %0d want 0", frame_cnt); end
        rst = 1'b0;
        href = 1'b0;
        clear_log();
        repeat (2) @(negedge clk);
        send_line(H, 8'h0A, 8'hBC, 0);
        send_line(H, 8'h0A, 8'hBC, 0);
        checks++;
        if (wq_a.size() != 0) begin errors++; $display("FAIL mid_nowrite: got %0d want 0", wq_a.size()); end
        frame_end();
        frame_start();
        send_line(H, 8'h0A, 8'hBC, 0);
        frame_end();
        check_order("mid_restart", H, 12'hABC);
        checks++;
        if (frame_cnt !== 8'd1) begin errors++; $display("FAIL mid_fcnt2: got %0d want 1", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_latency();
        test_short_line();
        test_overflow();
        test_en_gating();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
